// File: rtl/inst_issue_queue.sv
// rtl/inst_issue_queue.sv - fetch-to-issue instruction buffer with dual pop and delay-slot tracking
module inst_issue_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall_id,
  input  logic          in_valid1,
  input  logic          in_valid2,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst1,
  input  logic [31:0]   in_inst2,
  input  logic          issue_mode,
  output logic          out_valid1,
  output logic          out_valid2,
  output logic [31:0]   out_pc1,
  output logic [31:0]   out_pc2,
  output logic [31:0]   out_inst1,
  output logic [31:0]   out_inst2,
  output logic          first_in_delayslot_o,
  output logic          full_o,
  output logic [AW:0]   count_o
);

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [AW:0]   count_q, count_d;
  logic          ds_q, ds_d;
  logic [1:0]    push_n, pop_n;
  logic          push_ok;

  function automatic logic is_branch(input logic [31:0] inst);
    case (inst[31:26])
      6'h00:   is_branch = (inst[5:0] == 6'h08) || (inst[5:0] == 6'h09);
      6'h01:   is_branch = (inst[20:16] == 5'h00) || (inst[20:16] == 5'h01) ||
                           (inst[20:16] == 5'h10) || (inst[20:16] == 5'h11);
      6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: is_branch = 1'b1;
      default: is_branch = 1'b0;
    endcase
  endfunction

  assign head1      = head_q + AW'(1);
  assign tail1      = tail_q + AW'(1);
  assign out_valid1 = (count_q != '0);
  assign out_valid2 = (count_q >= (AW+1)'(2));
  assign out_pc1    = pc_q[head_q];
  assign out_pc2    = pc_q[head1];
  assign out_inst1  = inst_q[head_q];
  assign out_inst2  = inst_q[head1];
  assign full_o     = (count_q > (AW+1)'(DEPTH - 2));
  assign count_o    = count_q;
  assign first_in_delayslot_o = ds_q;
  assign push_ok    = !full_o && !flush && in_valid1;

  always_comb begin
    push_n = 2'd0;
    pop_n  = 2'd0;
    if (in_valid1) push_n = in_valid2 ? 2'd2 : 2'd1;
    if (!stall_id && out_valid1) pop_n = (issue_mode && out_valid2) ? 2'd2 : 2'd1;

    head_d  = head_q + AW'(pop_n);
    tail_d  = tail_q + (push_ok ? AW'(push_n) : '0);
    count_d = count_q + (push_ok ? (AW+1)'(push_n) : '0) - (AW+1)'(pop_n);

    case (pop_n)
      2'd1:    ds_d = is_branch(out_inst1);
      2'd2:    ds_d = 1'b0;
      default: ds_d = ds_q;
    endcase

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ds_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ds_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ds_q    <= ds_d;
    end
  end

  // Payload storage carries no reset; validity comes solely from count_q.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_q[tail_q]   <= in_pc;
      inst_q[tail_q] <= in_inst1;
      if (in_valid2) begin
        pc_q[tail1]   <= in_pc + 32'd4;
        inst_q[tail1] <= in_inst2;
      end
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// tb/tb_inst_issue_queue.sv - randomized scoreboard bench for inst_issue_queue
module tb_inst_issue_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, stall_id = 1'b0, in_valid1 = 1'b0, in_valid2 = 1'b0;
  logic [31:0] in_pc = '0, in_inst1 = '0, in_inst2 = '0;
  logic        issue_mode = 1'b0;
  logic        out_valid1, out_valid2, first_in_delayslot_o, full_o;
  logic [31:0] out_pc1, out_pc2, out_inst1, out_inst2;
  logic [AW:0] count_o;

  inst_issue_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id),
    .in_valid1(in_valid1), .in_valid2(in_valid2), .in_pc(in_pc),
    .in_inst1(in_inst1), .in_inst2(in_inst2), .issue_mode(issue_mode),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_pc1(out_pc1), .out_pc2(out_pc2), .out_inst1(out_inst1), .out_inst2(out_inst2),
    .first_in_delayslot_o(first_in_delayslot_o), .full_o(full_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } entry_t;
  typedef struct {
    logic v1, v2, ds, full;
    logic [31:0] pc1, pc2, inst1, inst2;
    int count;
  } exp_t;

  entry_t mq[$];
  exp_t   expq[$];
  bit     mflag = 0;
  int     checks = 0;
  int     errors = 0;

  localparam logic [31:0] BEQ  = 32'h1022_0003;
  localparam logic [31:0] JR   = 32'h03E0_0008;
  localparam logic [31:0] ADDU = 32'h0085_1021;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  logic [31:0] itab [8] = '{32'h1022_0003, 32'h03E0_0008, 32'h0800_0010, 32'h0411_0004,
                            32'h0085_1021, 32'h2442_0001, 32'h8C43_0000, 32'h0402_0001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_branch(input logic [31:0] inst);
    logic [5:0] op = inst[31:26];
    logic [4:0] rt = inst[20:16];
    logic [5:0] fn = inst[5:0];
    if (op >= 6'd2 && op <= 6'd7) return 1;
    if (op == 6'd0) return fn == 6'h08 || fn == 6'h09;
    if (op == 6'd1) return rt == 5'h00 || rt == 5'h01 || rt == 5'h10 || rt == 5'h11;
    return 0;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.count = mq.size();
    e.v1 = mq.size() >= 1;
    e.v2 = mq.size() >= 2;
    e.full = mq.size() > DEPTH - 2;
    e.ds = mflag;
    e.pc1 = e.v1 ? mq[0].pc : '0;
    e.inst1 = e.v1 ? mq[0].inst : '0;
    e.pc2 = e.v2 ? mq[1].pc : '0;
    e.inst2 = e.v2 ? mq[1].inst : '0;
    return e;
  endfunction

  task automatic cyc(input logic fl, input logic st, input logic v1, input logic v2,
                     input logic [31:0] pc, input logic [31:0] i1, input logic [31:0] i2,
                     input logic md);
    int pop;
    bit was_full;
    @(negedge clk);
    flush = fl; stall_id = st; in_valid1 = v1; in_valid2 = v2;
    in_pc = pc; in_inst1 = i1; in_inst2 = i2; issue_mode = md;
    was_full = mq.size() > DEPTH - 2;
    if (fl) begin
      mq.delete();
      mflag = 0;
    end else begin
      pop = (st || mq.size() == 0) ? 0 : (md && mq.size() >= 2) ? 2 : 1;
      if (pop == 1) mflag = ref_branch(mq[0].inst);
      else if (pop == 2) mflag = 0;
      repeat (pop) void'(mq.pop_front());
      if (!was_full && v1) begin
        mq.push_back('{pc, i1});
        if (v2) mq.push_back('{pc + 32'd4, i2});
      end
    end
    expq.push_back(snapshot());
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("count", 32'(count_o), e.count);
        chk("valid1", 32'(out_valid1), 32'(e.v1));
        chk("valid2", 32'(out_valid2), 32'(e.v2));
        chk("full", 32'(full_o), 32'(e.full));
        chk("delayslot", 32'(first_in_delayslot_o), 32'(e.ds));
        if (e.v1) begin
          chk("pc1", out_pc1, e.pc1);
          chk("inst1", out_inst1, e.inst1);
        end
        if (e.v2) begin
          chk("pc2", out_pc2, e.pc2);
          chk("inst2", out_inst2, e.inst2);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] pc;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_valid1", 32'(out_valid1), 0);
    chk("rst_valid2", 32'(out_valid2), 0);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_ds", 32'(first_in_delayslot_o), 0);
    @(negedge clk);
    rst = 1'b1;

    cyc(0, 0, 1, 1, 32'hBFC0_0000, ADDU, NOP, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    cyc(0, 1, 1, 0, 32'h0000_1000, ADDU, NOP, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 32'h0000_2000 + 32'(i * 8), ADDU, NOP, 0);
    #3;
    chk("full_at7", 32'(full_o), 1);
    chk("count7", 32'(count_o), 7);
    cyc(0, 1, 1, 1, 32'h0000_3000, NOP, NOP, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    chk("count5_after_dual", 32'(count_o), 5);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);

    cyc(0, 1, 1, 1, 32'h8000_0000, BEQ, ADDU, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("beq_ds_set", 32'(first_in_delayslot_o), 1);
    chk("beq_slot_pc", out_pc1, 32'h8000_0004);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("beq_ds_clr", 32'(first_in_delayslot_o), 0);

    cyc(0, 1, 1, 1, 32'h8000_0100, JR, NOP, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 32'h8000_0200, ADDU, NOP, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    chk("single_left_valid1", 32'(out_valid1), 0);

    cyc(0, 1, 1, 1, 32'h8000_0300, ADDU, ADDU, 0);
    cyc(0, 1, 1, 1, 32'h8000_0308, ADDU, ADDU, 0);
    cyc(0, 1, 1, 0, 32'h8000_0310, ADDU, NOP, 0);
    cyc(1, 0, 1, 1, 32'h8000_0400, BEQ, NOP, 1);
    #3;
    chk("flush_count", 32'(count_o), 0);

    pc = 32'h9000_0000;
    cyc(0, 1, 1, 0, pc, ADDU, NOP, 0);
    pc += 4;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cyc(0, 0, 1, 1, pc, itab[$urandom_range(4, 7)], itab[$urandom_range(4, 7)], 1);
      pc += 8;
    end

    cyc(0, 1, 1, 1, 32'hA000_0000, ADDU, ADDU, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count_o), 0);
    chk("async_rst_valid1", 32'(out_valid1), 0);
    chk("async_rst_ds", 32'(first_in_delayslot_o), 0);
    mq.delete();
    mflag = 0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
          itab[$urandom_range(0, 7)], itab[$urandom_range(0, 7)],
          $urandom_range(0, 1) == 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
